ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter AHB_ADDR_WIDTH, default 32, AHB address width.
REQ-002 SHALL have parameter AHB_DATA_WIDTH, default 32, AHB data width (only 32 supported).
REQ-003 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words in the array.
REQ-004 SHALL have ports (one clock; reset asynchronous, active-low):
- clk  in  1  clock
- rstn  in  1  async active-low reset
- hsel_i  in  1  slave select
- haddr_i  in  AHB_ADDR_WIDTH  address
- hwdata_i  in  AHB_DATA_WIDTH  write data (data phase)
- hwrite_i  in  1  1=write
- hsize_i  in  3  transfer size
- hburst_i  in  3  ignored
- hprot_i  in  4  ignored
- htrans_i  in  2  transfer type
- hmastlock_i  in  1  ignored
- hready_i  in  1  bus ready
- hrdata_o  out  AHB_DATA_WIDTH  read data
- hreadyout_o  out  1  slave ready
- hresp_o  out  1  1=ERROR

Function
REQ-005 SHALL accept an address phase only when hsel_i && hready_i && htrans_i[1] (NONSEQ/SEQ); IDLE/BUSY or unselected → OKAY, zero wait, no access.
REQ-006 SHALL decode offset = haddr_i mod (MEM_WORDS*4); word index = offset[..:2].
REQ-007 SHALL flag error at address phase if hsize_i>2, hsize_i=1 with haddr_i[0]=1, hsize_i=2 with haddr_i[1:0]≠0, or haddr_i ≥ MEM_WORDS*4.
REQ-008 SHALL derive byte enables: byte → 1 lane at haddr_i[1:0]; half → lanes {1:0} or {3:2}; word → all four.
REQ-009 SHALL register address, write flag, byte enables at address phase; write SHALL commit hwdata_i lanes at end of data phase cycle.
REQ-010 SHALL return read data on hrdata_o in the data phase cycle following address phase, hreadyout_o=1 (zero wait), full word regardless of hsize.
REQ-011 SHALL forward: read address phase coinciding with write data phase to the same word returns merged data (written lanes from hwdata_i, others from array).
REQ-012 SHALL implement FSM states OKAY, ERR1, ERR2 (plus RWAIT per REQ-018).
REQ-013 OKAY → ERR1 on erroneous accepted transfer; ERR1: hresp_o=1, hreadyout_o=0; ERR1 → ERR2; ERR2: hresp_o=1, hreadyout_o=1; ERR2 → OKAY, or ERR1 if a new erroneous transfer is accepted.
REQ-014 Erroneous transfers SHALL NOT modify the array.
REQ-015 hrdata_o SHALL hold last read value when no read data phase is active.
REQ-016 Back-to-back pipelined transfers (new address phase during data phase) SHALL be sustained at one transfer per cycle with no wait states.

Reset
REQ-017 While rstn=0: FSM=OKAY, hreadyout_o=1, hresp_o=0, hrdata_o=0, pending data phase discarded (no write commits); array contents not reset.

Configuration
REQ-018 Macro AHB_SRAM_READ_WAIT_EN: when defined, every read data phase SHALL insert exactly one wait state (state RWAIT, hreadyout_o=0, hresp_o=0), data valid the following cycle with hreadyout_o=1; writes and errors unchanged. When undefined, reads are zero-wait per REQ-010 and RWAIT does not exist.

Verification
REQ-019 Word write 0x0000_0010 ← 0xDEADBEEF, then word read 0x10 → hrdata_o=0xDEADBEEF, hresp_o=0, no wait states.
REQ-020 Byte write 0x11 ← hwdata 0x0000_AA00 over word 0x11223344 → read 0x10 returns 0x1122AA44.
REQ-021 Write 0x20 ← 0xCAFEF00D immediately followed by read 0x20 (pipelined) → read returns 0xCAFEF00D.
REQ-022 Word read at 0x02 (unaligned) → hresp_o=1/hreadyout_o=0 then hresp_o=1/hreadyout_o=1, then OKAY; write to 0x1000 (MEM_WORDS=1024) → same ERROR pair, array unchanged.
REQ-023 rstn low during write data phase to 0x30 (old 0x0) → after reset read 0x30 returns 0x0, outputs at reset values.
REQ-024 With AHB_SRAM_READ_WAIT_EN: read 0x10 → one cycle hreadyout_o=0, next cycle hreadyout_o=1 with data; write still zero-wait.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite slave fronting a single-port word-organised SRAM array.
// Zero-wait reads and writes, byte/halfword/word writes via lane enables,
// write-to-read forwarding for pipelined accesses to the same word, and the
// two-cycle ERROR response for misaligned, oversized or out-of-range transfers.
//
// Optional build macro: AHB_SRAM_READ_WAIT_EN
//   When defined, every read data phase gets one wait state (state RWAIT)
//   and the read data is presented in the cycle after it.
//
// Ports:
//   clk          clock
//   rstn         asynchronous active-low reset
//   hsel_i       slave select
//   haddr_i      address (address phase)
//   hwdata_i     write data (data phase)
//   hwrite_i     1 = write
//   hsize_i      transfer size (0 byte, 1 half, 2 word)
//   hburst_i     ignored
//   hprot_i      ignored
//   htrans_i     transfer type (bit 1 set = NONSEQ/SEQ)
//   hmastlock_i  ignored
//   hready_i     bus ready (previous data phase completes)
//   hrdata_o     read data
//   hreadyout_o  slave ready
//   hresp_o      1 = ERROR
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int MEM_WORDS      = 1024
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      hsel_i,
    input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
    input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
    input  logic                      hwrite_i,
    input  logic [2:0]                hsize_i,
    input  logic [2:0]                hburst_i,
    input  logic [3:0]                hprot_i,
    input  logic [1:0]                htrans_i,
    input  logic                      hmastlock_i,
    input  logic                      hready_i,
    output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
    output logic                      hreadyout_o,
    output logic                      hresp_o
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [AHB_ADDR_WIDTH:0] MEM_BYTES = (AHB_ADDR_WIDTH + 1)'(MEM_WORDS * 4);

    localparam logic [1:0] ST_OKAY  = 2'd0;
    localparam logic [1:0] ST_ERR1  = 2'd1;
    localparam logic [1:0] ST_ERR2  = 2'd2;
`ifdef AHB_SRAM_READ_WAIT_EN
    localparam logic [1:0] ST_RWAIT = 2'd3;
`endif

    // Lane enables for a transfer; misaligned/oversized cases are rejected
    // by the error decode, so their value here does not matter.
    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            3'd0:    be = 4'b0001 << a;
            3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            3'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    logic [AHB_DATA_WIDTH-1:0] mem_r [0:MEM_WORDS-1];

    logic                      acc_s;
    logic                      err_s;
    logic                      acc_ok_s;
    logic                      acc_err_s;
    logic [IDX_W-1:0]          idx_s;
    logic [3:0]                be_s;
    logic                      wr_commit_s;
    logic [1:0]                state_nxt_s;
    logic                      hreadyout_nxt_s;
    logic                      hresp_nxt_s;

    logic                      dp_valid_r;
    logic                      dp_write_r;
    logic [IDX_W-1:0]          dp_idx_r;
    logic [3:0]                dp_be_r;
    logic [1:0]                state_r;
    logic                      hreadyout_r;
    logic                      hresp_r;
    logic [AHB_DATA_WIDTH-1:0] hrdata_r;

    // Sideband inputs carry no meaning for a plain SRAM.
    logic unused_s;
    assign unused_s = ^{hburst_i, hprot_i, hmastlock_i, htrans_i[0]};

    assign acc_s = hsel_i && hready_i && htrans_i[1];
    assign idx_s = haddr_i[IDX_W+1:2];
    assign be_s  = lane_enables(hsize_i, haddr_i[1:0]);

    // Address-phase error decode: size, alignment and range.
    always_comb begin
        err_s = 1'b0;
        if (hsize_i > 3'd2) begin
            err_s = 1'b1;
        end else if ((hsize_i == 3'd1) && haddr_i[0]) begin
            err_s = 1'b1;
        end else if ((hsize_i == 3'd2) && (haddr_i[1:0] != 2'b00)) begin
            err_s = 1'b1;
        end else if ({1'b0, haddr_i} >= MEM_BYTES) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end

    assign acc_ok_s    = acc_s && !err_s;
    assign acc_err_s   = acc_s && err_s;
    // Only accepted, error-free writes ever reach the array.
    assign wr_commit_s = dp_valid_r && dp_write_r;

`ifndef AHB_SRAM_READ_WAIT_EN
    logic [AHB_DATA_WIDTH-1:0] fwd_word_s;

    // Read word with lanes of a same-word write in its data phase overlaid,
    // since that write only lands in the array at this same clock edge.
    always_comb begin
        fwd_word_s = mem_r[idx_s];
        for (int i = 0; i < 4; i++) begin
            fwd_word_s[8*i +: 8] = (wr_commit_s && (dp_idx_r == idx_s) && dp_be_r[i])
                                   ? hwdata_i[8*i +: 8] : mem_r[idx_s][8*i +: 8];
        end
    end
`endif

    // Response FSM next state and the registered outputs it implies.
    always_comb begin
        state_nxt_s = ST_OKAY;
        case (state_r)
            ST_OKAY, ST_ERR2: begin
                if (acc_err_s) begin
                    state_nxt_s = ST_ERR1;
`ifdef AHB_SRAM_READ_WAIT_EN
                end else if (acc_ok_s && !hwrite_i) begin
                    state_nxt_s = ST_RWAIT;
`endif
                end else begin
                    state_nxt_s = ST_OKAY;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_OKAY;
        endcase

        hreadyout_nxt_s = 1'b1;
        hresp_nxt_s     = 1'b0;
        case (state_nxt_s)
            ST_ERR1: begin
                hreadyout_nxt_s = 1'b0;
                hresp_nxt_s     = 1'b1;
            end
            ST_ERR2: begin
                hreadyout_nxt_s = 1'b1;
                hresp_nxt_s     = 1'b1;
            end
`ifdef AHB_SRAM_READ_WAIT_EN
            ST_RWAIT: begin
                hreadyout_nxt_s = 1'b0;
                hresp_nxt_s     = 1'b0;
            end
`endif
            default: begin
                hreadyout_nxt_s = 1'b1;
                hresp_nxt_s     = 1'b0;
            end
        endcase
    end

    // Data-phase pipeline, FSM state and registered bus outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dp_valid_r  <= 1'b0;
            dp_write_r  <= 1'b0;
            dp_idx_r    <= {IDX_W{1'b0}};
            dp_be_r     <= 4'b0000;
            state_r     <= ST_OKAY;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
            hrdata_r    <= {AHB_DATA_WIDTH{1'b0}};
        end else begin
            dp_valid_r  <= acc_ok_s;
            dp_write_r  <= acc_ok_s && hwrite_i;
            if (acc_ok_s) begin
                dp_idx_r <= idx_s;
                dp_be_r  <= be_s;
            end
            state_r     <= state_nxt_s;
            hreadyout_r <= hreadyout_nxt_s;
            hresp_r     <= hresp_nxt_s;
`ifdef AHB_SRAM_READ_WAIT_EN
            // Array is read during the wait cycle; no write can be pending then.
            if (state_r == ST_RWAIT) begin
                hrdata_r <= mem_r[dp_idx_r];
            end
`else
            if (acc_ok_s && !hwrite_i) begin
                hrdata_r <= fwd_word_s;
            end
`endif
        end
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (dp_be_r[i]) begin
                    mem_r[dp_idx_r][8*i +: 8] <= hwdata_i[8*i +: 8];
                end
            end
        end
    end

    assign hrdata_o    = hrdata_r;
    assign hreadyout_o = hreadyout_r;
    assign hresp_o     = hresp_r;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
// Directed bench for ahb_sram_slave: a per-cycle vector table (address-phase
// inputs, this cycle's write data, expected outputs after the edge) plus
// hand-written sequences for error responses and reset during a write.
// hready_i is looped back from hreadyout_o as in a single-slave system.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

    logic        clk;
    logic        rstn;
    logic        hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic        hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic        hresp;

    int checks;
    int failures;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSEQ = 2'b10;

    typedef struct {
        logic        sel;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_rdy;
        logic        exp_resp;
    } vec_t;

    ahb_sram_slave #(
        .AHB_ADDR_WIDTH(32),
        .AHB_DATA_WIDTH(32),
        .MEM_WORDS(1024)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .hsel_i(hsel),
        .haddr_i(haddr),
        .hwdata_i(hwdata),
        .hwrite_i(hwrite),
        .hsize_i(hsize),
        .hburst_i(hburst),
        .hprot_i(hprot),
        .htrans_i(htrans),
        .hmastlock_i(hmastlock),
        .hready_i(hready),
        .hrdata_o(hrdata),
        .hreadyout_o(hreadyout),
        .hresp_o(hresp)
    );

    assign hready = hreadyout;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string name, input logic rdy, input logic resp);
        chk({name, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, rdy});
        chk({name, ".hresp"}, {31'd0, hresp}, {31'd0, resp});
    endtask

    // Drive one cycle of inputs, then sample #1 after the rising edge.
    task automatic cyc(input logic sel, input logic [31:0] addr, input logic wr,
                       input logic [2:0] size, input logic [1:0] trans, input logic [31:0] wd);
        hsel   = sel;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = trans;
        hwdata = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic sel, input logic [31:0] addr, input logic wr,
                                 input logic [2:0] size, input logic [1:0] trans,
                                 input logic [31:0] wd, input logic chk_rd,
                                 input logic [31:0] exp_rd);
        vec_t v;
        v.sel = sel; v.addr = addr; v.wr = wr; v.size = size; v.trans = trans;
        v.wdata = wd; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
        v.exp_rdy = 1'b1; v.exp_resp = 1'b0;
        return v;
    endfunction

    // Two-cycle ERROR response followed by return to OKAY; read data must hold.
    task automatic err_seq(input string name, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [31:0] hold);
        cyc(1'b1, addr, wr, size, NSEQ, 32'h0);
        chk_bus({name, ".err1"}, 1'b0, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'h1234_5678);
        chk_bus({name, ".err2"}, 1'b1, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'h0);
        chk_bus({name, ".okay"}, 1'b1, 1'b0);
        chk({name, ".hold"}, hrdata, hold);
    endtask

    vec_t vecs[18];

    initial begin
        checks    = 0;
        failures  = 0;
        rstn      = 1'b0;
        hsel      = 1'b0;
        haddr     = 32'h0;
        hwdata    = 32'h0;
        hwrite    = 1'b0;
        hsize     = 3'd0;
        hburst    = 3'd0;
        hprot     = 4'd0;
        htrans    = IDLE;
        hmastlock = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk_bus("reset", 1'b1, 1'b0);
        chk("reset.hrdata", hrdata, 32'h0);
        rstn = 1'b1;

`ifndef AHB_SRAM_READ_WAIT_EN
        //             sel   addr          wr    size  trans wdata         chk   exp
        vecs[0]  = mkv(1'b1, 32'h0000_0010, 1'b1, 3'd2, NSEQ, 32'h0,        1'b0, 32'h0);
        vecs[1]  = mkv(1'b1, 32'h0,         1'b0, 3'd2, IDLE, 32'hDEADBEEF, 1'b0, 32'h0);
        vecs[2]  = mkv(1'b1, 32'h0000_0010, 1'b0, 3'd2, NSEQ, 32'h0,        1'b1, 32'hDEADBEEF);
        vecs[3]  = mkv(1'b1, 32'h0000_0010, 1'b1, 3'd2, NSEQ, 32'h0,        1'b1, 32'hDEADBEEF);
        vecs[4]  = mkv(1'b1, 32'h0000_0011, 1'b1, 3'd0, NSEQ, 32'h11223344, 1'b0, 32'h0);
        vecs[5]  = mkv(1'b1, 32'h0000_0010, 1'b0, 3'd2, NSEQ, 32'h0000AA00, 1'b1, 32'h1122AA44);
        vecs[6]  = mkv(1'b1, 32'h0000_0020, 1'b1, 3'd2, NSEQ, 32'h0,        1'b1, 32'h1122AA44);
        vecs[7]  = mkv(1'b1, 32'h0000_0020, 1'b0, 3'd2, NSEQ, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
        vecs[8]  = mkv(1'b1, 32'h0000_0022, 1'b1, 3'd1, NSEQ, 32'h0,        1'b1, 32'hCAFEF00D);
        vecs[9]  = mkv(1'b1, 32'h0000_0024, 1'b1, 3'd2, NSEQ, 32'h55660000, 1'b0, 32'h0);
        vecs[10] = mkv(1'b1, 32'h0000_0020, 1'b0, 3'd2, NSEQ, 32'h99887766, 1'b1, 32'h5566F00D);
        vecs[11] = mkv(1'b1, 32'h0000_0024, 1'b0, 3'd2, NSEQ, 32'h0,        1'b1, 32'h99887766);
        vecs[12] = mkv(1'b0, 32'h0000_0020, 1'b1, 3'd2, NSEQ, 32'h0,        1'b1, 32'h99887766);
        vecs[13] = mkv(1'b1, 32'h0,         1'b0, 3'd2, IDLE, 32'hFFFFFFFF, 1'b1, 32'h99887766);
        vecs[14] = mkv(1'b1, 32'h0000_0020, 1'b0, 3'd2, NSEQ, 32'h0,        1'b1, 32'h5566F00D);
        vecs[15] = mkv(1'b1, 32'h0000_0020, 1'b1, 3'd2, BUSY, 32'h0,        1'b1, 32'h5566F00D);
        vecs[16] = mkv(1'b1, 32'h0,         1'b0, 3'd2, IDLE, 32'hFFFFFFFF, 1'b1, 32'h5566F00D);
        vecs[17] = mkv(1'b1, 32'h0000_0013, 1'b0, 3'd0, NSEQ, 32'h0,        1'b1, 32'h1122AA44);

        for (int i = 0; i < 18; i++) begin
            cyc(vecs[i].sel, vecs[i].addr, vecs[i].wr, vecs[i].size, vecs[i].trans, vecs[i].wdata);
            chk_bus($sformatf("vec%0d", i), vecs[i].exp_rdy, vecs[i].exp_resp);
            if (vecs[i].chk_rd) begin
                chk($sformatf("vec%0d.hrdata", i), hrdata, vecs[i].exp_rd);
            end
        end

        // Unaligned word read.
        err_seq("unaligned_rd", 32'h0000_0002, 1'b0, 3'd2, 32'h1122AA44);

        // Out-of-range write must not alias onto word 0.
        cyc(1'b1, 32'h0000_0000, 1'b1, 3'd2, NSEQ, 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'hA5A5A5A5);
        err_seq("range_wr", 32'h0000_1000, 1'b1, 3'd2, 32'h1122AA44);
        cyc(1'b1, 32'h0000_0000, 1'b0, 3'd2, NSEQ, 32'h0);
        chk_bus("range_wr.rd0", 1'b1, 1'b0);
        chk("range_wr.rd0.hrdata", hrdata, 32'hA5A5A5A5);

        // Misaligned halfword, then a new error accepted in ERR2 re-enters ERR1.
        cyc(1'b1, 32'h0000_0011, 1'b0, 3'd1, NSEQ, 32'h0);
        chk_bus("b2b.err1a", 1'b0, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'h0);
        chk_bus("b2b.err2a", 1'b1, 1'b1);
        cyc(1'b1, 32'h0000_0010, 1'b0, 3'd3, NSEQ, 32'h0);
        chk_bus("b2b.err1b", 1'b0, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'h0);
        chk_bus("b2b.err2b", 1'b1, 1'b1);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'h0);
        chk_bus("b2b.okay", 1'b1, 1'b0);
        chk("b2b.hold", hrdata, 32'hA5A5A5A5);

        // Reset asserted during a write data phase discards the write.
        cyc(1'b1, 32'h0000_0030, 1'b1, 3'd2, NSEQ, 32'h0);
        cyc(1'b1, 32'h0000_0030, 1'b1, 3'd2, NSEQ, 32'h0);
        hsel   = 1'b1;
        htrans = IDLE;
        hwdata = 32'h77777777;
        rstn   = 1'b0;
        @(posedge clk);
        #1;
        chk_bus("rst_wr", 1'b1, 1'b0);
        chk("rst_wr.hrdata", hrdata, 32'h0);
        rstn = 1'b1;
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'h0);
        cyc(1'b1, 32'h0000_0030, 1'b0, 3'd2, NSEQ, 32'h0);
        chk_bus("rst_wr.rd", 1'b1, 1'b0);
        chk("rst_wr.rd.hrdata", hrdata, 32'h0);
`else
        // One wait state on reads, writes stay zero-wait.
        cyc(1'b1, 32'h0000_0010, 1'b1, 3'd2, NSEQ, 32'h0);
        chk_bus("rw.wr_addr", 1'b1, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'hDEADBEEF);
        chk_bus("rw.wr_data", 1'b1, 1'b0);
        cyc(1'b1, 32'h0000_0010, 1'b0, 3'd2, NSEQ, 32'h0);
        chk_bus("rw.wait", 1'b0, 1'b0);
        cyc(1'b1, 32'h0, 1'b0, 3'd2, IDLE, 32'h0);
        chk_bus("rw.data", 1'b1, 1'b0);
        chk("rw.data.hrdata", hrdata, 32'hDEADBEEF);
        err_seq("rw.unaligned_rd", 32'h0000_0002, 1'b0, 3'd2, 32'hDEADBEEF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
